// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if
// Bundles every signal between the two ALU requesters, the shared ALU and
// the alu_share_arb sequencer.
//   req0_* / req1_* : operation request channels (valid/ready, operands,
//                     control code, signed-compare select)
//   rsp0_* / rsp1_* : result response channels (valid/ready, data)
//   alu_*           : operands/control driven to the combinational ALU and
//                     its result
// Modports:
//   slave  : the arbiter side (accepts requests, drives responses and ALU)
//   master : the environment side (requesters plus the ALU instance)
interface alu_share_arb_if #(
    parameter int DATA_W = 32,
    parameter int CTL_W  = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_in1;
    logic [DATA_W-1:0] req0_in2;
    logic [CTL_W-1:0]  req0_ctl;
    logic              req0_sign;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_in1;
    logic [DATA_W-1:0] req1_in2;
    logic [CTL_W-1:0]  req1_ctl;
    logic              req1_sign;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_data;

    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_data;

    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [CTL_W-1:0]  alu_ctl;
    logic              alu_sign;
    logic [DATA_W-1:0] alu_out;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_ctl, req0_sign,
        output req0_ready,
        input  req1_valid, req1_in1, req1_in2, req1_ctl, req1_sign,
        output req1_ready,
        output rsp0_valid, rsp0_data,
        input  rsp0_ready,
        output rsp1_valid, rsp1_data,
        input  rsp1_ready,
        output alu_in1, alu_in2, alu_ctl, alu_sign,
        input  alu_out
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_ctl, req0_sign,
        input  req0_ready,
        output req1_valid, req1_in1, req1_in2, req1_ctl, req1_sign,
        input  req1_ready,
        input  rsp0_valid, rsp0_data,
        output rsp0_ready,
        input  rsp1_valid, rsp1_data,
        output rsp1_ready,
        input  alu_in1, alu_in2, alu_ctl, alu_sign,
        output alu_out
    );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb
// Shares one combinational ALU between the main execute path (port 0) and
// the auxiliary address/compare unit (port 1). One operation is in flight at
// a time: IDLE accepts a request, EXEC drives the latched operands into the
// ALU for exactly one cycle and captures alu_out, RESP holds the result on
// the owner's response channel until it is taken.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : alu_share_arb_if.slave (request, response and ALU channels)
//   busy  : high whenever the sequencer is not in IDLE
// Configuration macro:
//   ALU_SHARE_ARB_RR_EN : defined -> round-robin on simultaneous requests;
//                         undefined -> fixed priority, port 0 wins ties.
module alu_share_arb #(
    parameter int DATA_W = 32,
    parameter int CTL_W  = 5
) (
    input  logic           clk,
    input  logic           reset,
    alu_share_arb_if.slave bus,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              owner;       // port that owns the in-flight op
    logic              last_grant;  // port of the most recent accept
    logic [DATA_W-1:0] result;

    logic tie_to_0;
    logic grant0;
    logic grant1;
    logic rsp_take;

    always_comb begin
`ifdef ALU_SHARE_ARB_RR_EN
        // A tie goes to the port not served last.
        tie_to_0 = last_grant;
`else
        // Fixed priority: last_grant is still tracked but never steers ties.
        tie_to_0 = last_grant | 1'b1;
`endif
        grant0 = bus.req0_valid & (~bus.req1_valid | tie_to_0);
        grant1 = bus.req1_valid & ~grant0;

        bus.req0_ready = (state == IDLE) & grant0;
        bus.req1_ready = (state == IDLE) & grant1;

        // Both ports show the result register; only rsp_valid is per-owner.
        bus.rsp0_data = result;
        bus.rsp1_data = result;

        rsp_take = owner ? (bus.rsp1_valid & bus.rsp1_ready)
                         : (bus.rsp0_valid & bus.rsp0_ready);
    end

    // The alu_* registers double as the operand latches: loaded on accept,
    // so they carry the operands only during EXEC and are zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            result         <= '0;
            busy           <= 1'b0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.alu_in1    <= '0;
            bus.alu_in2    <= '0;
            bus.alu_ctl    <= '0;
            bus.alu_sign   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        owner        <= grant1;
                        last_grant   <= grant1;
                        bus.alu_in1  <= grant1 ? bus.req1_in1  : bus.req0_in1;
                        bus.alu_in2  <= grant1 ? bus.req1_in2  : bus.req0_in2;
                        bus.alu_ctl  <= grant1 ? bus.req1_ctl  : bus.req0_ctl;
                        bus.alu_sign <= grant1 ? bus.req1_sign : bus.req0_sign;
                        busy         <= 1'b1;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    result         <= bus.alu_out;
                    bus.rsp0_valid <= ~owner;
                    bus.rsp1_valid <= owner;
                    bus.alu_in1    <= '0;
                    bus.alu_in2    <= '0;
                    bus.alu_ctl    <= '0;
                    bus.alu_sign   <= 1'b0;
                    state          <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        bus.rsp0_valid <= 1'b0;
                        bus.rsp1_valid <= 1'b0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    bus.rsp0_valid <= 1'b0;
                    bus.rsp1_valid <= 1'b0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb
// Directed bench for alu_share_arb with a small reference ALU attached to
// the ALU channel (AND, ADD, SLT/SLTU, SRA; other codes return 0).
// Honours ALU_SHARE_ARB_RR_EN to select the expected tie-break order.
module tb_alu_share_arb;

    localparam logic [4:0] C_ADD = 5'b00010;
    localparam logic [4:0] C_SLT = 5'b00111;
    localparam logic [4:0] C_SRA = 5'b11001;
    localparam logic [4:0] C_BAD = 5'b11111;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    alu_share_arb_if #(.DATA_W(32), .CTL_W(5)) bus ();

    alu_share_arb #(.DATA_W(32), .CTL_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        case (bus.alu_ctl)
            5'b00000: bus.alu_out = bus.alu_in1 & bus.alu_in2;
            5'b00010: bus.alu_out = bus.alu_in1 + bus.alu_in2;
            5'b00111: bus.alu_out = {31'b0, bus.alu_sign ?
                                     ($signed(bus.alu_in1) < $signed(bus.alu_in2)) :
                                     (bus.alu_in1 < bus.alu_in2)};
            5'b11001: bus.alu_out = $unsigned($signed(bus.alu_in2) >>> bus.alu_in1[4:0]);
            default:  bus.alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] c, input logic s);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_in1 = a; bus.req0_in2 = b;
            bus.req0_ctl = c; bus.req0_sign = s;
        end else begin
            bus.req1_valid = v; bus.req1_in1 = a; bus.req1_in2 = b;
            bus.req1_ctl = c; bus.req1_sign = s;
        end
    endtask

    // One op with rsp_ready held high: ready in cycle T, EXEC in T+1,
    // response in T+2, back to IDLE in T+3.
    task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] c, input logic s, input logic [31:0] exp);
        logic own_ready, oth_ready, own_valid, oth_valid;
        set_req(port, 1'b1, a, b, c, s);
        #1;
        own_ready = (port == 0) ? bus.req0_ready : bus.req1_ready;
        oth_ready = (port == 0) ? bus.req1_ready : bus.req0_ready;
        chk("ready_owner", own_ready, 1);
        chk("ready_other", oth_ready, 0);
        chk("busy_idle", busy, 0);
        step();
        set_req(port, 1'b0, a, b, c, s);
        chk("exec_busy", busy, 1);
        chk("exec_alu_in1", bus.alu_in1, a);
        chk("exec_alu_in2", bus.alu_in2, b);
        chk("exec_alu_ctl", bus.alu_ctl, c);
        chk("exec_alu_sign", bus.alu_sign, s);
        chk("exec_rsp0_valid", bus.rsp0_valid, 0);
        chk("exec_rsp1_valid", bus.rsp1_valid, 0);
        step();
        own_valid = (port == 0) ? bus.rsp0_valid : bus.rsp1_valid;
        oth_valid = (port == 0) ? bus.rsp1_valid : bus.rsp0_valid;
        chk("resp_valid_owner", own_valid, 1);
        chk("resp_valid_other", oth_valid, 0);
        chk("resp_data0", bus.rsp0_data, exp);
        chk("resp_data1", bus.rsp1_data, exp);
        chk("resp_busy", busy, 1);
        chk("resp_alu_in1_idle", bus.alu_in1, 0);
        chk("resp_alu_ctl_idle", bus.alu_ctl, 0);
        step();
        chk("done_rsp0_valid", bus.rsp0_valid, 0);
        chk("done_rsp1_valid", bus.rsp1_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    int   n_acc;
    logic seq [8];
    logic exp_seq [4];

    initial begin
        reset = 1'b1;
        set_req(0, 1'b0, 0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0, 0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 0);
        chk("rst_rsp0_data", bus.rsp0_data, 0);
        chk("rst_alu_in1", bus.alu_in1, 0);
        chk("rst_alu_in2", bus.alu_in2, 0);
        chk("rst_alu_ctl", bus.alu_ctl, 0);
        chk("rst_alu_sign", bus.alu_sign, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);

        // ADD 5+7 on port 0
        run_op(0, 32'd5, 32'd7, C_ADD, 1'b0, 32'd12);

        // SLT signed / unsigned on port 1
        run_op(1, 32'hFFFF_FFFF, 32'd1, C_SLT, 1'b1, 32'd1);
        run_op(1, 32'hFFFF_FFFF, 32'd1, C_SLT, 1'b0, 32'd0);

        // Both ports request continuously; last accept was port 1
        set_req(0, 1'b1, 32'd1, 32'd2, C_ADD, 1'b0);
        set_req(1, 1'b1, 32'd3, 32'd4, C_ADD, 1'b0);
        n_acc = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (bus.req0_valid && bus.req0_ready && n_acc < 8) begin
                seq[n_acc] = 1'b0; n_acc++;
            end
            if (bus.req1_valid && bus.req1_ready && n_acc < 8) begin
                seq[n_acc] = 1'b1; n_acc++;
            end
        end
        set_req(0, 1'b0, 32'd1, 32'd2, C_ADD, 1'b0);
        set_req(1, 1'b0, 32'd3, 32'd4, C_ADD, 1'b0);
`ifdef ALU_SHARE_ARB_RR_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        chk("tie_accept_count", n_acc, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tie_accept_%0d", i), (i < n_acc) ? seq[i] : 1'bx, exp_seq[i]);
        end
        step();
        step();
        chk("tie_end_busy", busy, 0);

        // Backpressure on port 0 with a waiting port 1 request
        bus.rsp0_ready = 1'b0;
        set_req(0, 1'b1, 32'd4, 32'h8000_0000, C_SRA, 1'b0);
        #1;
        chk("bp_ready0", bus.req0_ready, 1);
        step();
        set_req(0, 1'b0, 32'd4, 32'h8000_0000, C_SRA, 1'b0);
        set_req(1, 1'b1, 32'd1, 32'd1, C_ADD, 1'b0);
        #1;
        chk("bp_exec_ready1", bus.req1_ready, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp0_valid", bus.rsp0_valid, 1);
            chk("bp_rsp0_data", bus.rsp0_data, 32'hF800_0000);
            chk("bp_ready0_low", bus.req0_ready, 0);
            chk("bp_ready1_low", bus.req1_ready, 0);
            chk("bp_rsp1_valid", bus.rsp1_valid, 0);
            step();
        end
        bus.rsp0_ready = 1'b1;
        #1;
        chk("bp_last_valid", bus.rsp0_valid, 1);
        chk("bp_last_ready1", bus.req1_ready, 0);
        step();
        chk("bp_released_valid", bus.rsp0_valid, 0);
        chk("bp_released_ready1", bus.req1_ready, 1);
        run_op(1, 32'd1, 32'd1, C_ADD, 1'b0, 32'd2);

        // Reset during EXEC, then re-issue
        set_req(0, 1'b1, 32'd10, 32'd20, C_ADD, 1'b0);
        step();
        set_req(0, 1'b0, 32'd10, 32'd20, C_ADD, 1'b0);
        chk("rex_busy", busy, 1);
        chk("rex_alu_in1", bus.alu_in1, 32'd10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rex_after_busy", busy, 0);
        chk("rex_after_rsp0_valid", bus.rsp0_valid, 0);
        chk("rex_after_rsp1_valid", bus.rsp1_valid, 0);
        chk("rex_after_alu_in1", bus.alu_in1, 0);
        step();
        chk("rex_idle_rsp0_valid", bus.rsp0_valid, 0);
        chk("rex_idle_busy", busy, 0);
        run_op(0, 32'd10, 32'd20, C_ADD, 1'b0, 32'd30);

        // Unknown control code passes through and yields 0
        run_op(1, 32'd3, 32'd4, C_BAD, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Arbiter and sequencer that shares the single combinational ALU between two requesters: the main execute path (port 0) and an auxiliary address/compare unit (port 1). It accepts one operation at a time through a valid/ready handshake and drives the latched operands into the ALU for exactly one cycle. It registers the result and holds it on the winning requester's response channel until that requester accepts it. It sits between the requesters and the ALU instance and owns every ALU input.

## Interface
- DATA_W, 32, operand/result width
- CTL_W, 5, ALU control code width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester N has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle (handshake = valid & ready)
- req0_in1, req0_in2 / req1_in1, req1_in2  in  DATA_W  operands (in1 carries shamt[4:0] for shifts)
- req0_ctl / req1_ctl  in  CTL_W  ALU control code
- req0_sign / req1_sign  in  1  signed compare select for SLT
- rsp0_valid / rsp1_valid  out  1  result available for requester N
- rsp0_ready / rsp1_ready  in  1  requester N takes the result
- rsp0_data / rsp1_data  out  DATA_W  result
- alu_in1, alu_in2  out  DATA_W  to ALU
- alu_ctl  out  CTL_W  to ALU
- alu_sign  out  1  to ALU
- alu_out  in  DATA_W  from ALU
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states are IDLE, EXEC and RESP.
- IDLE: the grant is combinational from the req valids and the priority rule. Only the granted port sees reqN_ready=1; the other port's ready stays 0. On handshake the block latches in1, in2, ctl, sign and the owner ID, then moves to EXEC. With no valid request it stays in IDLE.
- EXEC (1 cycle): alu_in1/in2/ctl/sign are driven from the latches. alu_out is captured into the result register and the FSM moves to RESP.
- RESP: rspN_valid=1 for the owner only, and rspN_data equals the captured result. Both stay stable until rspN_ready=1. On that handshake the FSM returns to IDLE.
- Outside EXEC, alu_in1=alu_in2=0, alu_ctl=0 and alu_sign=0, so the ALU idles on AND and outputs 0.
- Non-owner rsp_valid is always 0, and rsp_data on both ports shows the result register.
- Unknown ctl codes pass through unchanged; the ALU returns 0 and the result is delivered normally.
- last_grant updates on every accept to the accepted port ID.

## Timing
- Reset values: state=IDLE, last_grant=1 (port 0 wins the first tie), all rsp_valid=0, result=0, busy=0, ALU outputs=0.
- Latency: if the handshake occurs on edge T, EXEC runs in cycle T+1 and rsp_valid is high from edge T+2. With rsp_ready held high, the next accept is possible at edge T+3. Peak rate is one op per 3 cycles.
- req_ready is never high outside IDLE. A request arriving in EXEC or RESP waits and must hold valid and operands stable.
- Simultaneous valids in IDLE are resolved by the priority rule (see Configuration); the loser's ready stays 0.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Reset mid-operation (EXEC or RESP): the block returns to IDLE next edge and drops rsp_valid. The in-flight op is discarded and the requester re-issues it.
- The ALU is combinational, so alu_out is sampled in the same cycle the inputs are driven.

## Configuration
- ALU_SHARE_ARB_RR_EN defined: round-robin. On a tie the grant goes to the port that is not last_grant, so alternating ties serve 0,1,0,1,…
- ALU_SHARE_ARB_RR_EN undefined: fixed priority, so port 0 always wins ties. last_grant is still maintained but does not affect the grant.
- The single-requester behaviour is identical in both builds.

## Test plan
- Reset, then port 0 issues ADD (ctl=00010) with in1=5, in2=7. Expect ready0 at T, rsp0_valid at T+2 with data=12, busy=1 for cycles T+1..T+2.
- Port 1 issues SLT (ctl=00111, sign=1) with in1=0xFFFFFFFF and in2=1. Expect rsp1_data=1 and rsp0_valid=0 throughout. Repeat with sign=0 and expect 0.
- Both ports hold valid continuously with rsp_ready=1.
  - RR_EN build: accepts alternate 0,1,0,1.
  - Non-RR build: all accepts go to port 0 while req0_valid=1.
- Backpressure: hold rsp0_ready=0 for 5 cycles after an SRA (ctl=11001, in1=4, in2=0x80000000). rsp0_data must stay 0xF8000000 and ready0/ready1 must stay 0 until the handshake.
- Assert reset during EXEC. Next cycle: IDLE, rsp_valid=0, no result delivered. The re-issued op then completes normally.
- Unknown ctl=11111 with in1=3, in2=4 produces rsp data=0, delivered with standard 3-cycle timing.
